// File: rtl/comporta_sequenciador_pkg.sv
// rtl/comporta_sequenciador_pkg.sv - shared state encoding and timing defaults for the gate servo path
package comporta_sequenciador_pkg;

    typedef enum logic [3:0] {
        REPOUSO  = 4'd0,
        ABRINDO  = 4'd1,
        ABERTA   = 4'd2,
        FECHANDO = 4'd3,
        FIM      = 4'd4
    } estado_t;

    // Shared with the PWM generator and the dispenser FD so all agree on servo timing.
    localparam int POS_W_PADRAO        = 3;
    localparam int POS_MAX_PADRAO      = 7;
    localparam int T_PASSO_PADRAO      = 50_000;
    localparam int T_MAX_ABERTO_PADRAO = 5_000_000;

endpackage

// File: rtl/comporta_sequenciador_contador_passo.sv
// rtl/comporta_sequenciador_contador_passo.sv - modulo-N counter with clear/enable and terminal-count tick
module comporta_sequenciador_contador_passo #(
    parameter int N = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] ULTIMO = W'(N - 1);
    localparam logic [W-1:0] UM     = W'(1);

    logic [W-1:0] contagem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable) begin
            contagem <= tick ? '0 : contagem + UM;
        end
    end

    // Tick is a plain decode; the caller decides whether it matters in the current state.
    assign tick = (contagem == ULTIMO);

endmodule

// File: rtl/comporta_sequenciador.sv
// rtl/comporta_sequenciador.sv - gate servo sequencer: ramp open, hold until weight/timeout, ramp closed
module comporta_sequenciador
    import comporta_sequenciador_pkg::*;
#(
    parameter int POS_W        = POS_W_PADRAO,
    parameter int POS_MAX      = POS_MAX_PADRAO,
    parameter int T_PASSO      = T_PASSO_PADRAO,
    parameter int T_MAX_ABERTO = T_MAX_ABERTO_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             abrir,
    input  logic             peso_atingido,
    input  logic             cancelar,
    output logic [POS_W-1:0] posicao,
    output logic             pronto,
    output logic             aberta,
    output logic             fim,
    output logic             erro_timeout,
    output logic [3:0]       db_estado
);

    localparam logic [POS_W-1:0] POS_TOPO   = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_PENULT = POS_W'(POS_MAX - 1);
    localparam logic [POS_W-1:0] UM         = POS_W'(1);

    estado_t          estado, estadoProx;
    logic [POS_W-1:0] posicaoReg, posicaoProx;
    logic             erroReg, erroProx;
    logic             limpaPasso, contaPasso, tickPasso;
    logic             limpaAberto, contaAberto, tickAberto;

    comporta_sequenciador_contador_passo #(.N(T_PASSO)) uPasso (
        .clock  (clock),
        .reset  (reset),
        .clear  (limpaPasso),
        .enable (contaPasso),
        .tick   (tickPasso)
    );

    comporta_sequenciador_contador_passo #(.N(T_MAX_ABERTO)) uAberto (
        .clock  (clock),
        .reset  (reset),
        .clear  (limpaAberto),
        .enable (contaAberto),
        .tick   (tickAberto)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= REPOUSO;
            posicaoReg <= '0;
            erroReg    <= 1'b0;
        end else begin
            estado     <= estadoProx;
            posicaoReg <= posicaoProx;
            erroReg    <= erroProx;
        end
    end

    always_comb begin
        estadoProx  = estado;
        posicaoProx = posicaoReg;
        erroProx    = erroReg;
        limpaPasso  = 1'b1;
        contaPasso  = 1'b0;
        limpaAberto = 1'b1;
        contaAberto = 1'b0;
        unique case (estado)
            REPOUSO: begin
                if (abrir) begin
                    erroProx   = 1'b0;
                    estadoProx = peso_atingido ? FIM : ABRINDO;
                end
            end
            ABRINDO: begin
                // Abort beats the step tick so the gate never moves further open.
                if (cancelar || peso_atingido) begin
                    estadoProx = FECHANDO;
                end else begin
                    limpaPasso = 1'b0;
                    contaPasso = 1'b1;
                    if (tickPasso) begin
                        if (posicaoReg < POS_TOPO) posicaoProx = posicaoReg + UM;
                        if (posicaoReg >= POS_PENULT) estadoProx = ABERTA;
                    end
                end
            end
            ABERTA: begin
                limpaAberto = 1'b0;
                contaAberto = 1'b1;
                posicaoProx = POS_TOPO;
                if (peso_atingido || cancelar) begin
                    estadoProx = FECHANDO;
                end else if (tickAberto) begin
                    estadoProx = FECHANDO;
                    erroProx   = 1'b1;
                end
            end
            FECHANDO: begin
                limpaPasso = 1'b0;
                contaPasso = 1'b1;
                if (posicaoReg == '0) begin
                    estadoProx = FIM;
                end else if (tickPasso) begin
                    posicaoProx = posicaoReg - UM;
                    if (posicaoReg == UM) estadoProx = FIM;
                end
            end
            FIM: begin
                estadoProx = REPOUSO;
            end
            default: begin
                estadoProx = REPOUSO;
            end
        endcase
    end

    assign posicao      = posicaoReg;
    assign erro_timeout = erroReg;
    assign pronto       = (estado == REPOUSO);
    assign aberta       = (estado == ABERTA);
    assign fim          = (estado == FIM);
    assign db_estado    = estado;

endmodule

// File: tb/tb_comporta_sequenciador.sv
// tb/tb_comporta_sequenciador.sv - scoreboard bench for the gate servo sequencer
module tb_comporta_sequenciador;

    localparam int PERIODO = 10;

    typedef struct packed {
        logic [2:0] pos;
        logic       fim;
        int         gap;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       abrir = 1'b0;
    logic       peso_atingido = 1'b0;
    logic       cancelar = 1'b0;
    logic [2:0] posicao;
    logic       pronto, aberta, fim, erro_timeout;
    logic [3:0] db_estado;

    int         nCompared = 0;
    int         nFail = 0;
    ev_t        sb[$];
    logic [2:0] prevPos = '0;
    time        lastEvTime = 0;

    comporta_sequenciador #(
        .POS_W(3), .POS_MAX(3), .T_PASSO(4), .T_MAX_ABERTO(10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .abrir         (abrir),
        .peso_atingido (peso_atingido),
        .cancelar      (cancelar),
        .posicao       (posicao),
        .pronto        (pronto),
        .aberta        (aberta),
        .fim           (fim),
        .erro_timeout  (erro_timeout),
        .db_estado     (db_estado)
    );

    always #(PERIODO/2) clock = ~clock;

    task automatic push(input int pos, input bit f, input int gap);
        ev_t e;
        e.pos = 3'(pos);
        e.fim = f;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Waits for the next visible output event (position change or fim pulse).
    task automatic wait_event(input int budget, output ev_t obs, output bit ok);
        ok = 1'b0;
        obs = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (posicao !== prevPos || fim === 1'b1) begin
                obs.pos    = posicao;
                obs.fim    = fim;
                obs.gap    = int'(($time - lastEvTime) / PERIODO);
                prevPos    = posicao;
                lastEvTime = $time;
                ok         = 1'b1;
                return;
            end
        end
    endtask

    task automatic start_open();
        @(negedge clock);
        abrir = 1'b1;
        @(negedge clock);
        abrir = 1'b0;
        lastEvTime = $time;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        nCompared++; if (posicao !== 3'd0) begin nFail++; $display("FAIL reset_posicao: got %0d expected 0", posicao); end
        nCompared++; if (pronto !== 1'b1) begin nFail++; $display("FAIL reset_pronto: got %b expected 1", pronto); end
        nCompared++; if (aberta !== 1'b0 || fim !== 1'b0) begin nFail++; $display("FAIL reset_aberta_fim: got %b%b expected 00", aberta, fim); end
        nCompared++; if (erro_timeout !== 1'b0) begin nFail++; $display("FAIL reset_erro: got %b expected 0", erro_timeout); end
        nCompared++; if (db_estado !== 4'd0) begin nFail++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
        reset = 1'b0;
        @(negedge clock);
        prevPos = posicao;
        lastEvTime = $time;
    endtask

    task automatic test_full_cycle();
        ev_t obs, esp;
        bit ok;
        push(1, 0, 4); push(2, 0, 4); push(3, 0, 4);
        start_open();
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL full_open timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL full_open: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        nCompared++; if (aberta !== 1'b1) begin nFail++; $display("FAIL full_aberta: got %b expected 1", aberta); end
        repeat (5) @(negedge clock);
        peso_atingido = 1'b1;
        push(2, 0, 10); push(1, 0, 4); push(0, 1, 4);
        @(negedge clock);
        peso_atingido = 1'b0;
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL full_close timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL full_close: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        @(negedge clock);
        nCompared++; if (fim !== 1'b0 || pronto !== 1'b1 || db_estado !== 4'd0) begin nFail++; $display("FAIL full_rest: got fim=%b pronto=%b estado=%0d expected 0 1 0", fim, pronto, db_estado); end
        nCompared++; if (erro_timeout !== 1'b0) begin nFail++; $display("FAIL full_erro: got %b expected 0", erro_timeout); end
    endtask

    task automatic test_timeout();
        ev_t obs, esp;
        bit ok;
        int n;
        push(1, 0, 4); push(2, 0, 4); push(3, 0, 4);
        start_open();
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL tmo_open timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL tmo_open: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        n = 0;
        while (aberta === 1'b1 && n < 30) begin
            n++;
            @(negedge clock);
        end
        nCompared++; if (n != 10) begin nFail++; $display("FAIL tmo_aberta_cycles: got %0d expected 10", n); end
        push(2, 0, 14); push(1, 0, 4); push(0, 1, 4);
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL tmo_close timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL tmo_close: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        repeat (4) @(negedge clock);
        nCompared++; if (erro_timeout !== 1'b1) begin nFail++; $display("FAIL tmo_erro_sticky: got %b expected 1", erro_timeout); end
    endtask

    task automatic test_abort();
        ev_t obs, esp;
        bit ok;
        push(1, 0, 4); push(2, 0, 4);
        start_open();
        nCompared++; if (erro_timeout !== 1'b0) begin nFail++; $display("FAIL abort_erro_cleared: got %b expected 0", erro_timeout); end
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL abort_open timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL abort_open: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        cancelar = 1'b1;
        push(1, 0, 5); push(0, 1, 4);
        @(negedge clock);
        cancelar = 1'b0;
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL abort_close timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL abort_close: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
    endtask

    task automatic test_already_satisfied();
        int nFim;
        @(negedge clock);
        nCompared++; if (db_estado !== 4'd0) begin nFail++; $display("FAIL sat_start: got %0d expected 0", db_estado); end
        abrir = 1'b1;
        peso_atingido = 1'b1;
        @(negedge clock);
        abrir = 1'b0;
        peso_atingido = 1'b0;
        nCompared++; if (db_estado !== 4'd4 || fim !== 1'b1 || posicao !== 3'd0) begin nFail++; $display("FAIL sat_fim: got estado=%0d fim=%b pos=%0d expected 4 1 0", db_estado, fim, posicao); end
        @(negedge clock);
        nCompared++; if (db_estado !== 4'd0 || pronto !== 1'b1) begin nFail++; $display("FAIL sat_back: got estado=%0d pronto=%b expected 0 1", db_estado, pronto); end
        nFim = 0;
        repeat (5) begin
            @(negedge clock);
            if (fim === 1'b1 || posicao !== 3'd0) nFim++;
        end
        nCompared++; if (nFim != 0) begin nFail++; $display("FAIL sat_quiet: got %0d extra events expected 0", nFim); end
    endtask

    task automatic test_simultaneous();
        ev_t obs, esp;
        bit ok;
        push(1, 0, 4); push(2, 0, 4); push(3, 0, 4);
        start_open();
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL simul_open timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL simul_open: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        repeat (9) @(negedge clock);
        peso_atingido = 1'b1;
        @(negedge clock);
        peso_atingido = 1'b0;
        nCompared++; if (db_estado !== 4'd3 || erro_timeout !== 1'b0) begin nFail++; $display("FAIL simul_tmo_peso: got estado=%0d erro=%b expected 3 0", db_estado, erro_timeout); end
        push(2, 0, 14); push(1, 0, 4); push(0, 1, 4);
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL simul_close timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL simul_close: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        push(1, 0, 4);
        start_open();
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL simul_tick_open timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL simul_tick_open: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        repeat (3) @(negedge clock);
        peso_atingido = 1'b1;
        @(negedge clock);
        peso_atingido = 1'b0;
        nCompared++; if (posicao !== 3'd1 || db_estado !== 4'd3) begin nFail++; $display("FAIL simul_tick_noinc: got pos=%0d estado=%0d expected 1 3", posicao, db_estado); end
        push(0, 1, 8);
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL simul_tick_close timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL simul_tick_close: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
    endtask

    task automatic test_back_to_back();
        ev_t obs, esp;
        bit ok;
        repeat (2) @(negedge clock);
        abrir = 1'b1;
        peso_atingido = 1'b1;
        @(negedge clock);
        peso_atingido = 1'b0;
        nCompared++; if (db_estado !== 4'd4 || fim !== 1'b1) begin nFail++; $display("FAIL b2b_fim: got estado=%0d fim=%b expected 4 1", db_estado, fim); end
        @(negedge clock);
        nCompared++; if (db_estado !== 4'd0) begin nFail++; $display("FAIL b2b_repouso: got %0d expected 0", db_estado); end
        @(negedge clock);
        abrir = 1'b0;
        lastEvTime = $time;
        nCompared++; if (db_estado !== 4'd1) begin nFail++; $display("FAIL b2b_reaccept: got %0d expected 1", db_estado); end
        push(1, 0, 4);
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL b2b_open timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL b2b_open: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        cancelar = 1'b1;
        push(0, 1, 5);
        @(negedge clock);
        cancelar = 1'b0;
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL b2b_close timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL b2b_close: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
    endtask

    task automatic test_async_reset();
        ev_t obs, esp;
        bit ok;
        push(1, 0, 4); push(2, 0, 4); push(3, 0, 4);
        start_open();
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL arst_open timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL arst_open: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        cancelar = 1'b1;
        push(2, 0, 5);
        @(negedge clock);
        cancelar = 1'b0;
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL arst_down timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL arst_down: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        #2 reset = 1'b1;
        #1;
        nCompared++; if (posicao !== 3'd0 || pronto !== 1'b1 || db_estado !== 4'd0) begin nFail++; $display("FAIL arst_immediate: got pos=%0d pronto=%b estado=%0d expected 0 1 0", posicao, pronto, db_estado); end
        #1 reset = 1'b0;
        @(negedge clock);
        prevPos = posicao;
        nCompared++; if (db_estado !== 4'd0 || posicao !== 3'd0) begin nFail++; $display("FAIL arst_release: got estado=%0d pos=%0d expected 0 0", db_estado, posicao); end
        push(1, 0, 4);
        start_open();
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL arst_resume timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL arst_resume: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
        cancelar = 1'b1;
        push(0, 1, 5);
        @(negedge clock);
        cancelar = 1'b0;
        while (sb.size() > 0) begin
            wait_event(40, obs, ok);
            esp = sb.pop_front();
            nCompared++;
            if (!ok) begin nFail++; $display("FAIL arst_resume_close timeout: expected pos=%0d", esp.pos); sb.delete(); end
            else if (obs !== esp) begin nFail++; $display("FAIL arst_resume_close: got pos=%0d fim=%b gap=%0d expected pos=%0d fim=%b gap=%0d", obs.pos, obs.fim, obs.gap, esp.pos, esp.fim, esp.gap); end
        end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_timeout();
        test_abort();
        test_already_satisfied();
        test_timeout();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got %0d mismatches so far", nFail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/comporta_sequenciador.md
Name: comporta_sequenciador

Overview:
Sequencer for the dispenser gate (comporta) servo path. On an open request it ramps the servo position counter up one step per interval, holds the gate open until the target weight is reached or a timeout expires, then ramps back to closed. It drives the position value consumed by the PWM generator and reports status to the main control unit.

Parameters:
POS_W, 3, width of the servo position output
POS_MAX, 7, fully-open position (1..2^POS_W-1)
T_PASSO, 50_000, clock cycles between position steps (>=2)
T_MAX_ABERTO, 5_000_000, maximum cycles held in ABERTA before forced close (>=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
abrir  in  1  open request, level-sampled in REPOUSO only
peso_atingido  in  1  target weight reached (level)
cancelar  in  1  abort: close immediately from the current position
posicao  out  POS_W  servo position index to the PWM generator
pronto  out  1  high in REPOUSO only
aberta  out  1  high in ABERTA only
fim  out  1  one-cycle pulse in FIM
erro_timeout  out  1  sticky: last cycle closed by timeout
db_estado  out  4  state code for debug display

Behaviour:
- Reset is asynchronous and active-high. On reset: state REPOUSO, posicao=0, step and timeout counters 0, erro_timeout=0, fim=0, aberta=0, pronto=1. Reset mid-ramp snaps posicao to 0 with no ramp down.
- Internal counters: cnt_passo is $clog2(T_PASSO) bits and wraps at T_PASSO-1. cnt_aberto is $clog2(T_MAX_ABERTO) bits.
- "tick" means cnt_passo==T_PASSO-1.
- States and db_estado codes: REPOUSO=0, ABRINDO=1, ABERTA=2, FECHANDO=3, FIM=4. Unused codes go to REPOUSO.
- REPOUSO:
  - abrir=1 and peso_atingido=0 -> ABRINDO. Clear cnt_passo and erro_timeout.
  - abrir=1 and peso_atingido=1 -> FIM. Nothing to dispense, posicao stays 0.
- ABRINDO:
  - cnt_passo counts every cycle. On tick, posicao increments.
  - On the tick where posicao==POS_MAX-1: posicao becomes POS_MAX and the next state is ABERTA, with cnt_aberto cleared.
  - posicao=1 becomes visible T_PASSO cycles after entering ABRINDO.
  - cancelar or peso_atingido -> FECHANDO with cnt_passo cleared. This has priority over tick: no increment in that cycle.
- ABERTA:
  - posicao held at POS_MAX; cnt_aberto counts.
  - peso_atingido or cancelar -> FECHANDO.
  - Otherwise cnt_aberto==T_MAX_ABERTO-1 -> FECHANDO and erro_timeout set to 1.
  - If peso_atingido and timeout occur in the same cycle, peso_atingido wins and erro_timeout stays 0.
- FECHANDO:
  - On tick, posicao decrements.
  - On the tick where posicao==1: posicao becomes 0 and the next state is FIM.
  - Entering FECHANDO with posicao already 0 goes to FIM on the next cycle.
  - abrir, cancelar and peso_atingido are ignored.
- FIM: fim=1 for exactly one cycle, then REPOUSO. erro_timeout persists until the next accepted abrir.
- posicao saturates: it never exceeds POS_MAX and never goes below 0.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- abrir held high across FIM is re-accepted in REPOUSO on the following cycle. This is the back-to-back cycle case.

Decomposition:
- Shared package holds:
  - the state enum (REPOUSO..FIM) and its 4-bit db_estado encoding;
  - default T_PASSO and T_MAX_ABERTO constants, shared with the PWM and dispenser FD.
- One natural sub-module: contador_passo, a parameterised modulo-N counter with clear and enable that outputs the tick. It is instantiated twice: step timer and open timeout.
- The FSM and position up/down register stay in the top module.

Test Plan:
All scenarios use POS_MAX=3, T_PASSO=4, T_MAX_ABERTO=10.
- Full cycle: abrir pulse, peso_atingido asserted 5 cycles after aberta -> posicao 0,1,2,3 at 4-cycle spacing; aberta high; then posicao 2,1,0; one fim pulse; erro_timeout=0.
- Timeout: abrir, peso_atingido never asserted -> aberta for exactly 10 cycles, ramp down, fim pulse, erro_timeout=1 until the next abrir is accepted.
- Mid-ramp abort: cancelar when posicao=2 in ABRINDO -> no further increment; posicao goes 2,1,0 at 4-cycle steps; fim pulses.
- Already satisfied: abrir with peso_atingido=1 in REPOUSO -> db_estado 0->4->0; posicao stays 0; fim pulses once.
- Simultaneous: peso_atingido on the same cycle as timeout expiry -> FECHANDO with erro_timeout=0. Separately, peso_atingido on a tick cycle in ABRINDO -> posicao not incremented.
- Async reset asserted while posicao=2 during FECHANDO, between clock edges -> posicao=0, pronto=1, db_estado=0 immediately; normal operation resumes after release.
